wb_trace_buffer: RTL and testbench

Write-back trace capture for the 5-stage pipelined CPU. Sits beside the CPU's WB stage, snoops each retiring instruction (PC, instruction word, write-back data) into a circular buffer, and drains entries to a host or debug unit as a serialized 32-bit valid/ready stream of 3 words per entry. It is the producing end of the pipeline debug view: the CPU emits WB-stage signals, and this block records and streams them out. Capture can be armed freely or gated by a PC-match trigger.

---
 rtl/wb_trace_buffer.sv | 150 +++++++++++++++
 tb/tb_wb_trace_buffer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: snoops retiring WB-stage instructions into a circular
// buffer and streams each entry out as three 32-bit words (pc, ir, wdata).
// Capture runs freely once armed, or waits for a PC-match trigger first.
module wb_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wb_valid,
    input  logic [31:0]   wb_pc,
    input  logic [31:0]   wb_ir,
    input  logic [31:0]   wb_wdata,
    input  logic          arm,
    input  logic          stop,
    input  logic          clear,
    input  logic          trig_en,
    input  logic [31:0]   trig_pc,
    output logic [31:0]   dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic          dout_last,
    output logic [AW:0]   level,
    output logic          overflow,
    output logic [15:0]   drop_cnt,
    output logic [1:0]    state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);

    state_t        cur_state;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [1:0]    wsel;

    logic [31:0] mem_pc [DEPTH];
    logic [31:0] mem_ir [DEPTH];
    logic [31:0] mem_wd [DEPTH];

    logic capture_cyc;
    logic full;
    logic push;
    logic drop;
    logic hshake;
    logic pop;

    assign state = cur_state;

    // Decide whether this cycle's retirement is recorded; clear and stop
    // both suppress it, and the trigger cycle itself is captured.
    always_comb begin
        capture_cyc = 1'b0;
        if (!clear && !stop && wb_valid) begin
            if (cur_state == CAPTURE)
                capture_cyc = 1'b1;
            else if (cur_state == ARMED && wb_pc == trig_pc)
                capture_cyc = 1'b1;
        end
    end

    // Full is judged on the registered level, so a pop in the same cycle
    // does not make room for the incoming capture.
    assign full = (level == LEVEL_FULL);
    assign push = capture_cyc && !full;
    assign drop = capture_cyc && full;

    // Stream handshake: a word transfers on a cycle where dout_valid and
    // dout_ready are both high; while dout_valid is high and dout_ready is
    // low, dout and dout_last hold (they depend only on registered state),
    // and dout_valid never drops until the word is taken or the buffer is
    // cleared.
    assign dout_valid = (level != '0);
    assign hshake     = dout_valid && dout_ready;
    assign pop        = hshake && (wsel == 2'd2);
    assign dout_last  = dout_valid && (wsel == 2'd2);

    // Word mux for the entry at the read pointer; forced to zero when empty.
    always_comb begin
        dout = 32'h0;
        if (dout_valid) begin
            case (wsel)
                2'd0:    dout = mem_pc[rd_ptr];
                2'd1:    dout = mem_ir[rd_ptr];
                2'd2:    dout = mem_wd[rd_ptr];
                default: dout = 32'h0;
            endcase
        end
    end

    // Entry storage; written only on an accepted push, never reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr] <= wb_pc;
            mem_ir[wr_ptr] <= wb_ir;
            mem_wd[wr_ptr] <= wb_wdata;
        end
    end

    // Capture FSM, pointers, word select, level and drop bookkeeping.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cur_state <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            wsel      <= 2'd0;
            level     <= '0;
            overflow  <= 1'b0;
            drop_cnt  <= 16'h0;
        end else begin
            if (stop) begin
                cur_state <= IDLE;
            end else if (arm && cur_state == IDLE) begin
                cur_state <= trig_en ? ARMED : CAPTURE;
            end else if (cur_state == ARMED && capture_cyc) begin
                cur_state <= CAPTURE;
            end

            if (push)
                wr_ptr <= wr_ptr + 1'b1;

            if (hshake) begin
                if (wsel == 2'd2) begin
                    wsel   <= 2'd0;
                    rd_ptr <= rd_ptr + 1'b1;
                end else begin
                    wsel <= wsel + 2'd1;
                end
            end

            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase

            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 16'hFFFF)
                    drop_cnt <= drop_cnt + 16'h1;
            end
        end
    end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed bench for wb_trace_buffer: free-run and triggered capture,
// overflow, full-with-pop, backpressure, clear and reset mid-entry.
module tb_wb_trace_buffer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          wb_valid;
    logic [31:0]   wb_pc;
    logic [31:0]   wb_ir;
    logic [31:0]   wb_wdata;
    logic          arm;
    logic          stop;
    logic          clear;
    logic          trig_en;
    logic [31:0]   trig_pc;
    logic [31:0]   dout;
    logic          dout_valid;
    logic          dout_ready;
    logic          dout_last;
    logic [AW:0]   level;
    logic          overflow;
    logic [15:0]   drop_cnt;
    logic [1:0]    state;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    wb_trace_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .wb_valid   (wb_valid),
        .wb_pc      (wb_pc),
        .wb_ir      (wb_ir),
        .wb_wdata   (wb_wdata),
        .arm        (arm),
        .stop       (stop),
        .clear      (clear),
        .trig_en    (trig_en),
        .trig_pc    (trig_pc),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last),
        .level      (level),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt),
        .state      (state)
    );

    // Clock
    always #5 clk = ~clk;

    // Advance one rising edge and settle past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic retire(input logic [31:0] pc, input logic [31:0] ir, input logic [31:0] wd);
        wb_valid = 1'b1;
        wb_pc    = pc;
        wb_ir    = ir;
        wb_wdata = wd;
        step();
        wb_valid = 1'b0;
    endtask

    task automatic exp_entry(input logic [31:0] pc, input logic [31:0] ir, input logic [31:0] wd);
        exp_q.push_back(pc);
        exp_q.push_back(ir);
        exp_q.push_back(wd);
    endtask

    task automatic pulse_arm(input logic te);
        trig_en = te;
        arm     = 1'b1;
        step();
        arm     = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    // Sustained drain with ready held high; words must come back-to-back.
    task automatic drain_q();
        logic [31:0] e;
        int idx;
        idx = 0;
        dout_ready = 1'b1;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("drain_valid", {31'h0, dout_valid}, 32'h1);
            chk("drain_data", dout, e);
            chk("drain_last", {31'h0, dout_last}, {31'h0, (idx % 3 == 2)});
            step();
            idx++;
        end
        dout_ready = 1'b0;
    endtask

    // Directed sequence
    initial begin
        logic [31:0] e;
        rst = 1'b1; wb_valid = 1'b0; wb_pc = '0; wb_ir = '0; wb_wdata = '0;
        arm = 1'b0; stop = 1'b0; clear = 1'b0; trig_en = 1'b0; trig_pc = '0;
        dout_ready = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_state", {30'h0, state}, 32'h0);
        chk("rst_level", {27'h0, level}, 32'h0);
        chk("rst_valid", {31'h0, dout_valid}, 32'h0);
        chk("rst_last", {31'h0, dout_last}, 32'h0);
        chk("rst_ovf", {31'h0, overflow}, 32'h0);
        chk("rst_drop", {16'h0, drop_cnt}, 32'h0);

        // Free-run capture of three instructions
        pulse_arm(1'b0);
        chk("free_state", {30'h0, state}, 32'h2);
        retire(32'h0, 32'h00500093, 32'h5);
        chk("free_lat_valid", {31'h0, dout_valid}, 32'h1);
        chk("free_lat_word0", dout, 32'h0);
        retire(32'h4, 32'h00A00113, 32'hA);
        retire(32'h8, 32'h002081B3, 32'hF);
        chk("free_level3", {27'h0, level}, 32'h3);
        exp_entry(32'h0, 32'h00500093, 32'h5);
        exp_entry(32'h4, 32'h00A00113, 32'hA);
        exp_entry(32'h8, 32'h002081B3, 32'hF);
        drain_q();
        chk("free_level0", {27'h0, level}, 32'h0);
        chk("free_valid0", {31'h0, dout_valid}, 32'h0);
        pulse_stop();
        chk("free_stop_state", {30'h0, state}, 32'h0);

        // PC-match trigger at 0x10
        trig_pc = 32'h10;
        pulse_arm(1'b1);
        chk("trig_armed", {30'h0, state}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            retire(32'(i * 4), 32'h13 + 32'(i), 32'h100 + 32'(i * 4));
            chk("trig_wait_state", {30'h0, state}, 32'h1);
            chk("trig_wait_level", {27'h0, level}, 32'h0);
        end
        retire(32'h10, 32'h17, 32'h110);
        chk("trig_hit_state", {30'h0, state}, 32'h2);
        chk("trig_hit_level", {27'h0, level}, 32'h1);
        retire(32'h14, 32'h18, 32'h114);
        retire(32'h18, 32'h19, 32'h118);
        retire(32'h1C, 32'h1A, 32'h11C);
        chk("trig_level4", {27'h0, level}, 32'h4);
        exp_entry(32'h10, 32'h17, 32'h110);
        exp_entry(32'h14, 32'h18, 32'h114);
        exp_entry(32'h18, 32'h19, 32'h118);
        exp_entry(32'h1C, 32'h1A, 32'h11C);
        drain_q();
        pulse_stop();

        // Overflow: 20 retirements into a 16-deep buffer with no drain
        pulse_arm(1'b0);
        for (int i = 0; i < 20; i++)
            retire(32'h100 + 32'(i * 4), 32'hA000 + 32'(i), 32'hB000 + 32'(i));
        chk("ovf_level", {27'h0, level}, 32'd16);
        chk("ovf_flag", {31'h0, overflow}, 32'h1);
        chk("ovf_drop", {16'h0, drop_cnt}, 32'd4);
        for (int i = 0; i < 16; i++)
            exp_entry(32'h100 + 32'(i * 4), 32'hA000 + 32'(i), 32'hB000 + 32'(i));
        drain_q();
        chk("ovf_sticky", {31'h0, overflow}, 32'h1);
        chk("ovf_drained", {27'h0, level}, 32'h0);

        // Full buffer with a pop completing in the same cycle as a capture
        for (int i = 0; i < 16; i++)
            retire(32'h200 + 32'(i * 4), 32'hC000 + 32'(i), 32'hD000 + 32'(i));
        chk("fp_full", {27'h0, level}, 32'd16);
        dout_ready = 1'b1;
        chk("fp_w0", dout, 32'h200);
        step();
        chk("fp_w1", dout, 32'hC000);
        step();
        chk("fp_w2", dout, 32'hD000);
        chk("fp_w2_last", {31'h0, dout_last}, 32'h1);
        retire(32'h300, 32'hEEEE, 32'hFFFF);
        dout_ready = 1'b0;
        chk("fp_level15", {27'h0, level}, 32'd15);
        chk("fp_drop5", {16'h0, drop_cnt}, 32'd5);
        for (int i = 1; i < 16; i++)
            exp_entry(32'h200 + 32'(i * 4), 32'hC000 + 32'(i), 32'hD000 + 32'(i));
        drain_q();
        pulse_stop();

        // Backpressure: ready alternates, each word must hold through a stall
        pulse_arm(1'b0);
        retire(32'h400, 32'h1111, 32'h2222);
        retire(32'h404, 32'h3333, 32'h4444);
        pulse_stop();
        exp_entry(32'h400, 32'h1111, 32'h2222);
        exp_entry(32'h404, 32'h3333, 32'h4444);
        for (int i = 0; i < 6; i++) begin
            e = exp_q.pop_front();
            dout_ready = 1'b0;
            step();
            chk("bp_stall_valid", {31'h0, dout_valid}, 32'h1);
            chk("bp_stall_data", dout, e);
            chk("bp_stall_last", {31'h0, dout_last}, {31'h0, (i % 3 == 2)});
            dout_ready = 1'b1;
            step();
        end
        dout_ready = 1'b0;
        chk("bp_level0", {27'h0, level}, 32'h0);
        chk("bp_valid0", {31'h0, dout_valid}, 32'h0);

        // Clear after the word-1 handshake abandons the entry
        pulse_arm(1'b0);
        retire(32'h500, 32'h5555, 32'h6666);
        retire(32'h504, 32'h7777, 32'h8888);
        dout_ready = 1'b1;
        step();
        step();
        dout_ready = 1'b0;
        chk("clr_pre_word2", dout, 32'h6666);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_valid", {31'h0, dout_valid}, 32'h0);
        chk("clr_level", {27'h0, level}, 32'h0);
        chk("clr_ovf", {31'h0, overflow}, 32'h0);
        chk("clr_drop", {16'h0, drop_cnt}, 32'h0);
        chk("clr_state", {30'h0, state}, 32'h0);

        // Retirement coincident with arm is not captured, nor one with stop
        wb_valid = 1'b1; wb_pc = 32'h5FC; wb_ir = 32'h99; wb_wdata = 32'h98;
        pulse_arm(1'b0);
        wb_valid = 1'b0;
        chk("arm_same_cycle", {27'h0, level}, 32'h0);
        retire(32'h600, 32'hABCD, 32'h1234);
        wb_valid = 1'b1; wb_pc = 32'h604; wb_ir = 32'h97; wb_wdata = 32'h96;
        pulse_stop();
        wb_valid = 1'b0;
        chk("stop_same_cycle", {27'h0, level}, 32'h1);
        exp_entry(32'h600, 32'hABCD, 32'h1234);
        drain_q();

        // Reset mid-entry
        pulse_arm(1'b0);
        retire(32'h700, 32'h7070, 32'h7171);
        dout_ready = 1'b1;
        step();
        dout_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstm_valid", {31'h0, dout_valid}, 32'h0);
        chk("rstm_level", {27'h0, level}, 32'h0);
        chk("rstm_state", {30'h0, state}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
